// File: rtl/airlock_pkg.sv
// Shared types and defaults for the airlock chamber scheduler.
// Also imported by the arrival workflow bench.
package airlock_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_OPEN_ENTRY,
      S_CYCLE,
      S_OPEN_EXIT,
      S_DONE,
      S_FAULT
   } state_t;

   typedef enum logic {
      ARRIVE = 1'b0,
      DEPART = 1'b1
   } dir_t;

   localparam int PUMP_TIMEOUT_DEF = 16;
   localparam int DOOR_TIMEOUT_DEF = 32;

   function automatic int cnt_width(input int a, input int b);
      return $clog2(a > b ? a : b);
   endfunction

endpackage

// File: rtl/airlock_scheduler_if.sv
// Request, sensor and command bundle between the chamber and its scheduler.
// master is the chamber/requester side, slave is the scheduler.
interface airlock_scheduler_if;
   logic arriveReq;
   logic departReq;
   logic odClosed;
   logic idClosed;
   logic isHighPressure;
   logic arriveGrant;
   logic departGrant;
   logic busy;
   logic startPressurizing;
   logic startDepressurizing;
   logic odUnlock;
   logic idUnlock;
   logic fault;

   modport master (
      output arriveReq, departReq,
      output odClosed, idClosed, isHighPressure,
      input  arriveGrant, departGrant, busy,
      input  startPressurizing, startDepressurizing,
      input  odUnlock, idUnlock, fault
   );

   modport slave (
      input  arriveReq, departReq,
      input  odClosed, idClosed, isHighPressure,
      output arriveGrant, departGrant, busy,
      output startPressurizing, startDepressurizing,
      output odUnlock, idUnlock, fault
   );
endinterface

// File: rtl/airlock_timer.sv
// Clearable saturating phase counter, hit when it sits at i_limit.
// Shared by the pump and door phases of the scheduler.
module airlock_timer #(
   parameter int W = 5
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_limit,
   output logic         o_hit
);

   logic [W-1:0] r_cnt;

   assign o_hit = (r_cnt == i_limit);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_hit) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/airlock_scheduler.sv
// Airlock chamber owner: arbitrates arrival/departure and sequences
// pumps and doors with interlocks. All outputs are registered.
module airlock_scheduler
   import airlock_pkg::*;
#(
   parameter int PUMP_TIMEOUT = PUMP_TIMEOUT_DEF,
   parameter int DOOR_TIMEOUT = DOOR_TIMEOUT_DEF
) (
   input logic          clock,
   input logic          reset,
   airlock_scheduler_if.slave bus
);

   localparam int CW = cnt_width(PUMP_TIMEOUT, DOOR_TIMEOUT);
   localparam logic [CW-1:0] PUMP_LIM = CW'(PUMP_TIMEOUT - 1);
   localparam logic [CW-1:0] DOOR_LIM = CW'(DOOR_TIMEOUT - 1);

   state_t r_state, w_state_n;
   dir_t   r_dir, w_dir_n;
   dir_t   r_last_dir, w_last_n;
   logic   r_opened, w_opened_n;

   logic r_arr_gnt, r_dep_gnt, r_busy, r_fault;
   logic r_pup, r_pdn, r_od_unl, r_id_unl;

   logic          w_hit, w_clr, w_en;
   logic [CW-1:0] w_limit;
   logic          w_doors_ok, w_tgt_cur, w_tgt_n;
   logic          w_act_od, w_act_closed, w_oth_closed;
   logic          w_enter_pump, w_mid, w_unl, w_unl_od;

   assign w_doors_ok = bus.odClosed && bus.idClosed;
   assign w_tgt_cur  = (r_state == S_CYCLE) ^ (r_dir == DEPART);

   // Arrival entry door is outer; departure mirrors it
   assign w_act_od     = (r_state == S_OPEN_ENTRY) ^ (r_dir == DEPART);
   assign w_act_closed = w_act_od ? bus.odClosed : bus.idClosed;
   assign w_oth_closed = w_act_od ? bus.idClosed : bus.odClosed;

   assign w_limit = (r_state == S_PREP || r_state == S_CYCLE) ?
                    PUMP_LIM : DOOR_LIM;
   assign w_clr   = (w_state_n != r_state);

   airlock_timer #(.W(CW)) u_timer (
      .clock   (clock),
      .reset   (reset),
      .i_clr   (w_clr),
      .i_en    (w_en),
      .i_limit (w_limit),
      .o_hit   (w_hit)
   );

   always_comb begin
      w_state_n  = r_state;
      w_dir_n    = r_dir;
      w_last_n   = r_last_dir;
      w_opened_n = r_opened;
      w_en       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_doors_ok && (bus.arriveReq || bus.departReq)) begin
               w_state_n = S_PREP;
               if (bus.arriveReq && bus.departReq) begin
                  w_dir_n = (r_last_dir == DEPART) ? ARRIVE : DEPART;
               end else begin
                  w_dir_n = bus.arriveReq ? ARRIVE : DEPART;
               end
            end
         end
         S_PREP, S_CYCLE: begin
            w_en = 1'b1;
            if (!w_doors_ok) begin
               w_state_n = S_FAULT;
            end else if (bus.isHighPressure == w_tgt_cur) begin
               w_state_n = (r_state == S_PREP) ? S_OPEN_ENTRY : S_OPEN_EXIT;
            end else if (w_hit) begin
               w_state_n = S_FAULT;
            end
         end
         S_OPEN_ENTRY, S_OPEN_EXIT: begin
            if (!w_oth_closed) begin
               w_state_n = S_FAULT;
            end else if (!r_opened) begin
               w_en = 1'b1;
               if (!w_act_closed) begin
                  w_opened_n = 1'b1;
               end else if (w_hit) begin
                  w_state_n = (r_state == S_OPEN_ENTRY) ? S_IDLE : S_DONE;
               end
            end else if (w_act_closed) begin
               w_state_n = (r_state == S_OPEN_ENTRY) ? S_CYCLE : S_DONE;
            end
         end
         S_DONE: begin
            w_last_n  = r_dir;
            w_state_n = S_IDLE;
         end
         S_FAULT: begin
            w_state_n = S_FAULT;
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase
      if (w_state_n != r_state) begin
         w_opened_n = 1'b0;
      end
   end

   // Output decode looks at the next state so outputs stay registered
   assign w_tgt_n      = (w_state_n == S_CYCLE) ^ (w_dir_n == DEPART);
   assign w_enter_pump = (w_state_n != r_state) &&
                         (w_state_n == S_PREP || w_state_n == S_CYCLE);
   assign w_mid = (w_state_n == S_PREP) || (w_state_n == S_OPEN_ENTRY) ||
                  (w_state_n == S_CYCLE) || (w_state_n == S_OPEN_EXIT);
   assign w_unl    = (w_state_n == S_OPEN_ENTRY) ||
                     (w_state_n == S_OPEN_EXIT);
   assign w_unl_od = (w_state_n == S_OPEN_ENTRY) ^ (w_dir_n == DEPART);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_dir      <= ARRIVE;
         r_last_dir <= DEPART;
         r_opened   <= 1'b0;
         r_arr_gnt  <= 1'b0;
         r_dep_gnt  <= 1'b0;
         r_busy     <= 1'b0;
         r_fault    <= 1'b0;
         r_pup      <= 1'b0;
         r_pdn      <= 1'b0;
         r_od_unl   <= 1'b0;
         r_id_unl   <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_dir      <= w_dir_n;
         r_last_dir <= w_last_n;
         r_opened   <= w_opened_n;
         r_arr_gnt  <= w_mid && (w_dir_n == ARRIVE);
         r_dep_gnt  <= w_mid && (w_dir_n == DEPART);
         r_busy     <= (w_state_n != S_IDLE);
         r_fault    <= (w_state_n == S_FAULT);
         r_pup      <= w_enter_pump && w_tgt_n && !bus.isHighPressure;
         r_pdn      <= w_enter_pump && !w_tgt_n && bus.isHighPressure;
         r_od_unl   <= w_unl && w_unl_od;
         r_id_unl   <= w_unl && !w_unl_od;
      end
   end

   assign bus.arriveGrant         = r_arr_gnt;
   assign bus.departGrant         = r_dep_gnt;
   assign bus.busy                = r_busy;
   assign bus.fault               = r_fault;
   assign bus.startPressurizing   = r_pup;
   assign bus.startDepressurizing = r_pdn;
   assign bus.odUnlock            = r_od_unl;
   assign bus.idUnlock            = r_id_unl;

endmodule
